// File: rtl/rmii_dibit_crc_tx.sv
// RMII TX dibit stage: reorders MSB-dibit-first bytes into wire order (LSB dibit first) and runs CRC-32 on the wire stream.
// Optional `define CRC_RESIDUE_CHECK_EN adds crc_good, flagging a stream that already carried a correct FCS.
module rmii_dibit_crc_tx #(
   parameter logic [31:0] CRC_POLY = 32'h04C11DB7,
   parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [1:0]  in_data,
   input  logic        crc_en,
   output logic        txen,
   output logic [1:0]  txd,
   output logic        crc_valid,
   output logic [31:0] crc_out
`ifdef CRC_RESIDUE_CHECK_EN
   ,
   output logic        crc_good
`endif
);

   // write buffer holds the first three dibits; the fourth goes straight to txd
   logic [1:0]       cnt_q, cnt_d;
   logic [2:0][1:0]  wbuf_q, wbuf_d;
   logic [2:0][1:0]  rbuf_q, rbuf_d;
   logic [1:0]       rrem_q, rrem_d;
   logic             txen_q, txen_d;
   logic [1:0]       txd_q, txd_d;
   logic [31:0]      state_q, state_d;
   logic             crc_valid_q, crc_valid_d;
   logic [31:0]      crc_out_q, crc_out_d;
   logic             byte_done;
   logic             upd;

   function automatic logic [31:0] crc_dibit(input logic [31:0] s_in, input logic [1:0] d);
      logic [31:0] s;
      logic        fb;
      s = s_in;
      for (int i = 0; i < 2; i++) begin
         fb = s[31] ^ d[i];
         s  = {s[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      return s;
   endfunction

   assign byte_done = in_valid && (cnt_q == 2'd3);

   always_comb begin
      cnt_d  = cnt_q;
      wbuf_d = wbuf_q;
      if (!in_valid) begin
         cnt_d = 2'd0;
      end else begin
         cnt_d = cnt_q + 2'd1;
         case (cnt_q)
            2'd0:    wbuf_d[0] = in_data;
            2'd1:    wbuf_d[1] = in_data;
            2'd2:    wbuf_d[2] = in_data;
            default: ;
         endcase
      end
   end

   // read buffer is emitted from entry 0 upward, so load it in reverse capture order
   always_comb begin
      rbuf_d = rbuf_q;
      rrem_d = rrem_q;
      txen_d = 1'b0;
      txd_d  = 2'b00;
      if (byte_done) begin
         txen_d    = 1'b1;
         txd_d     = in_data;
         rbuf_d[0] = wbuf_q[2];
         rbuf_d[1] = wbuf_q[1];
         rbuf_d[2] = wbuf_q[0];
         rrem_d    = 2'd3;
      end else if (rrem_q != 2'd0) begin
         txen_d = 1'b1;
         txd_d  = rbuf_q[0];
         rbuf_d = {2'b00, rbuf_q[2:1]};
         rrem_d = rrem_q - 2'd1;
      end
   end

   assign upd = txen_q & crc_en;

   always_comb begin
      state_d = state_q;
      if (!crc_en)
         state_d = CRC_INIT;
      else if (upd)
         state_d = crc_dibit(state_q, txd_q);
      crc_valid_d = upd;
      crc_out_d   = upd ? ~state_d : crc_out_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= 2'd0;
         wbuf_q      <= '0;
         rbuf_q      <= '0;
         rrem_q      <= 2'd0;
         txen_q      <= 1'b0;
         txd_q       <= 2'b00;
         state_q     <= CRC_INIT;
         crc_valid_q <= 1'b0;
         crc_out_q   <= 32'h0;
      end else begin
         cnt_q       <= cnt_d;
         wbuf_q      <= wbuf_d;
         rbuf_q      <= rbuf_d;
         rrem_q      <= rrem_d;
         txen_q      <= txen_d;
         txd_q       <= txd_d;
         state_q     <= state_d;
         crc_valid_q <= crc_valid_d;
         crc_out_q   <= crc_out_d;
      end
   end

   assign txen      = txen_q;
   assign txd       = txd_q;
   assign crc_valid = crc_valid_q;
   assign crc_out   = crc_out_q;

`ifdef CRC_RESIDUE_CHECK_EN
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   logic crc_good_q;

   // aligned with crc_valid: judged on the same update that produced crc_out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         crc_good_q <= 1'b0;
      else
         crc_good_q <= upd && (state_d == CRC_RESIDUE);
   end

   assign crc_good = crc_good_q;
`endif

endmodule

// File: tb/tb_rmii_dibit_crc_tx.sv
// Directed bench for rmii_dibit_crc_tx: expected wire dibits are queued as bytes are sent and popped as txen appears.
module tb_rmii_dibit_crc_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_data;
   logic        crc_en;
   logic        txen;
   logic [1:0]  txd;
   logic        crc_valid;
   logic [31:0] crc_out;
`ifdef CRC_RESIDUE_CHECK_EN
   logic        crc_good;
`endif

   rmii_dibit_crc_tx dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .crc_en    (crc_en),
      .txen      (txen),
      .txd       (txd),
      .crc_valid (crc_valid),
      .crc_out   (crc_out)
`ifdef CRC_RESIDUE_CHECK_EN
      ,
      .crc_good  (crc_good)
`endif
   );

   always #5 clk = ~clk;

   int         errs = 0;
   int         checks = 0;
   logic [1:0] q[$];
   int         txen_hi = 0;
   int         txen_rise = 0;
   int         cv_cnt = 0;
   logic       txen_prev = 1'b0;
   logic       good_last = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock and score whatever the DUT drove on the wire
   task automatic tick();
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (txen) begin
         txen_hi++;
         if (!txen_prev) txen_rise++;
         chk("txen_expected", {31'd0, q.size() != 0}, 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("txd", {30'd0, txd}, {30'd0, e});
         end
      end else begin
         chk("txd_idle", {30'd0, txd}, 32'd0);
      end
      txen_prev = txen;
      if (crc_valid) begin
         cv_cnt++;
`ifdef CRC_RESIDUE_CHECK_EN
         good_last = crc_good;
`endif
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = b[7-2*k -: 2];
         if (k == 3) begin
            q.push_back(b[1:0]);
            q.push_back(b[3:2]);
            q.push_back(b[5:4]);
            q.push_back(b[7:6]);
         end
         tick();
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = 2'b00;
      repeat (n) tick();
   endtask

   function automatic logic [31:0] crc_model(input logic [7:0] b);
      logic [31:0] s;
      logic        fb;
      s = 32'hFFFFFFFF;
      for (int i = 0; i < 8; i++) begin
         fb = s[31] ^ b[i];
         s  = {s[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
      return ~s;
   endfunction

`ifdef CRC_RESIDUE_CHECK_EN
   function automatic logic [7:0] fcs_byte(input logic [31:0] r, input int k);
      logic [7:0] v;
      logic [7:0] o;
      v = r[31-8*k -: 8];
      for (int i = 0; i < 8; i++) o[i] = v[7-i];
      return o;
   endfunction
`endif

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 2'b00;
      crc_en   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_txen", {31'd0, txen}, 32'd0);
      chk("rst_txd", {30'd0, txd}, 32'd0);
      chk("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      chk("rst_crc_out", crc_out, 32'd0);
      rst = 1'b1;
      idle(2);

      // single byte 0xD5: wire order 01,01,01,11 four cycles after first dibit
      send_byte(8'hD5);
      chk("d5_latency", {31'd0, txen}, 32'd1);
      idle(3);
      chk("d5_last_txen", {31'd0, txen}, 32'd1);
      idle(1);
      chk("d5_txen_off", {31'd0, txen}, 32'd0);
      chk("d5_drained", q.size(), 32'd0);
      idle(2);

      // preamble + SFD back to back
      txen_hi = 0;
      txen_rise = 0;
      for (int i = 0; i < 8; i++) send_byte((i < 7) ? 8'h55 : 8'hD5);
      idle(6);
      chk("stream_txen_cycles", txen_hi, 32'd32);
      chk("stream_txen_runs", txen_rise, 32'd1);
      chk("stream_drained", q.size(), 32'd0);

      // CRC check string
      crc_en = 1'b1;
      cv_cnt = 0;
      for (int i = 0; i < 9; i++) send_byte(8'(8'h31 + i));
      idle(6);
      chk("crc_check_value", crc_out, 32'h649C2FD3);
      chk("crc_valid_cycles", cv_cnt, 32'd36);
      chk("crc_valid_off", {31'd0, crc_valid}, 32'd0);
      crc_en = 1'b0;
      idle(2);
      chk("crc_out_holds", crc_out, 32'h649C2FD3);

      // partial bytes are dropped
      txen_hi = 0;
      in_valid = 1'b1; in_data = 2'b10; tick();
      in_data = 2'b11; tick();
      idle(1);
      in_valid = 1'b1; in_data = 2'b01; tick();
      in_data = 2'b10; tick();
      in_data = 2'b11; tick();
      idle(1);
      send_byte(8'h31);
      idle(5);
      chk("partial_txen_cycles", txen_hi, 32'd4);
      chk("partial_drained", q.size(), 32'd0);

      // reset in the middle of byte 3
      crc_en = 1'b1;
      send_byte(8'h12);
      send_byte(8'h34);
      in_valid = 1'b1; in_data = 2'b01; tick();
      in_data = 2'b01; tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_txen", {31'd0, txen}, 32'd0);
      chk("mid_rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      chk("mid_rst_crc_out", crc_out, 32'd0);
      q.delete();
      txen_prev = 1'b0;
      in_valid = 1'b0;
      in_data = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      idle(1);
      send_byte(8'hA7);
      idle(5);
      chk("post_rst_crc", crc_out, crc_model(8'hA7));
      chk("post_rst_drained", q.size(), 32'd0);
      crc_en = 1'b0;
      idle(2);

`ifdef CRC_RESIDUE_CHECK_EN
      for (int pass = 0; pass < 2; pass++) begin
         crc_en = 1'b1;
         good_last = 1'b0;
         for (int i = 0; i < 9; i++) send_byte(8'(8'h31 + i));
         for (int k = 0; k < 4; k++)
            send_byte(fcs_byte(32'h649C2FD3, k) ^ ((pass == 1 && k == 3) ? 8'h10 : 8'h00));
         idle(6);
         chk(pass == 0 ? "residue_good" : "residue_bad", {31'd0, good_last}, pass == 0 ? 32'd1 : 32'd0);
         crc_en = 1'b0;
         idle(2);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
